// File: rtl/bram_tdp_param.sv
// True dual-port synchronous RAM with byte enables, selectable same-port
// read-during-write behaviour, optional output register and a post-reset clear pass.
module bram_tdp_param #(
  parameter int unsigned           DATA_WIDTH     = 16,
  parameter int unsigned           ADDR_WIDTH     = 9,
  parameter int unsigned           RDW_MODE       = 0,
  parameter bit                    OUT_REG        = 1'b0,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  parameter                        INIT_FILE      = "init.mif"
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    busy,
  input  logic                    en_a,
  input  logic                    we_a,
  input  logic [DATA_WIDTH/8-1:0] be_a,
  input  logic [ADDR_WIDTH-1:0]   addr_a,
  input  logic [DATA_WIDTH-1:0]   din_a,
  output logic [DATA_WIDTH-1:0]   dout_a,
  output logic                    rvalid_a,
  input  logic                    en_b,
  input  logic                    we_b,
  input  logic [DATA_WIDTH/8-1:0] be_b,
  input  logic [ADDR_WIDTH-1:0]   addr_b,
  input  logic [DATA_WIDTH-1:0]   din_b,
  output logic [DATA_WIDTH-1:0]   dout_b,
  output logic                    rvalid_b,
  output logic                    collision
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned NB    = DATA_WIDTH / 8;

  typedef enum logic {S_CLEAR = 1'b0, S_READY = 1'b1} state_t;

  state_t                  state_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   cnt_q;

  // Preload via INIT_FILE is attached by the vendor flow when no clear pass runs.
  (* ram_init_file = INIT_FILE *)
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    acc_a, acc_b, wr_a, wr_b;
  logic [DATA_WIDTH-1:0]   rd_a, rd_b, merged_a, merged_b;
  logic [DATA_WIDTH-1:0]   dout1_a_q, dout1_b_q;
  logic                    rv1_a_q, rv1_b_q, coll_q;

  // Handshake: an access is accepted when en_x is high and busy is low; every
  // accepted access (read or write) yields exactly one rvalid_x pulse, no backpressure.
  assign acc_a = en_a & ~busy_q;
  assign acc_b = en_b & ~busy_q;
  assign wr_a  = acc_a & we_a;
  assign wr_b  = acc_b & we_b;
  assign busy  = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      state_q <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      busy_q  <= CLEAR_ON_RESET;
    end else if (state_q == S_CLEAR) begin
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == '1) begin
        state_q <= S_READY;
        busy_q  <= 1'b0;
      end
    end
  end

  // Port A's byte lanes are assigned last so they win a same-address double write.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR && !rst) mem_q[cnt_q] <= CLEAR_VALUE;
    for (int i = 0; i < NB; i++) begin
      if (wr_b && be_b[i]) mem_q[addr_b][8*i +: 8] <= din_b[8*i +: 8];
      if (wr_a && be_a[i]) mem_q[addr_a][8*i +: 8] <= din_a[8*i +: 8];
    end
  end

  always_comb begin
    rd_a     = mem_q[addr_a];
    rd_b     = mem_q[addr_b];
    merged_a = rd_a;
    merged_b = rd_b;
    for (int i = 0; i < NB; i++) begin
      if (be_a[i]) merged_a[8*i +: 8] = din_a[8*i +: 8];
      if (be_b[i]) merged_b[8*i +: 8] = din_b[8*i +: 8];
    end
  end

  function automatic logic [DATA_WIDTH-1:0] rdw_sel(
    input logic                  we,
    input logic [DATA_WIDTH-1:0] rd,
    input logic [DATA_WIDTH-1:0] merged,
    input logic [DATA_WIDTH-1:0] cur
  );
    if (!we) return rd;
    case (RDW_MODE)
      0:       return merged;
      1:       return rd;
      default: return cur;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      dout1_a_q <= '0;
      dout1_b_q <= '0;
      rv1_a_q   <= 1'b0;
      rv1_b_q   <= 1'b0;
      coll_q    <= 1'b0;
    end else begin
      rv1_a_q <= acc_a;
      rv1_b_q <= acc_b;
      coll_q  <= wr_a & wr_b & (addr_a == addr_b);
      if (acc_a) dout1_a_q <= rdw_sel(we_a, rd_a, merged_a, dout1_a_q);
      if (acc_b) dout1_b_q <= rdw_sel(we_b, rd_b, merged_b, dout1_b_q);
    end
  end

  assign collision = coll_q;

  if (OUT_REG) begin : g_oreg
    logic [DATA_WIDTH-1:0] dout2_a_q, dout2_b_q;
    logic                  rv2_a_q, rv2_b_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        dout2_a_q <= '0;
        dout2_b_q <= '0;
        rv2_a_q   <= 1'b0;
        rv2_b_q   <= 1'b0;
      end else begin
        rv2_a_q <= rv1_a_q;
        rv2_b_q <= rv1_b_q;
        if (rv1_a_q) dout2_a_q <= dout1_a_q;
        if (rv1_b_q) dout2_b_q <= dout1_b_q;
      end
    end

    assign dout_a   = dout2_a_q;
    assign dout_b   = dout2_b_q;
    assign rvalid_a = rv2_a_q;
    assign rvalid_b = rv2_b_q;
  end else begin : g_noreg
    assign dout_a   = dout1_a_q;
    assign dout_b   = dout1_b_q;
    assign rvalid_a = rv1_a_q;
    assign rvalid_b = rv1_b_q;
  end

endmodule

// File: tb/tb_bram_tdp_param.sv
// Directed bench for bram_tdp_param: four instances share stimulus
// (write-first, read-first, no-change, write-first with output register).
module tb_bram_tdp_param;
  localparam int DW = 16;
  localparam int AW = 9;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          en_a, we_a, en_b, we_b;
  logic [1:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] din_a, din_b;

  logic [DW-1:0] dout_a [NI];
  logic [DW-1:0] dout_b [NI];
  logic          rv_a [NI];
  logic          rv_b [NI];
  logic          busy [NI];
  logic          coll [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    bram_tdp_param #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .RDW_MODE       ((g == 3) ? 0 : g),
      .OUT_REG        (g == 3),
      .CLEAR_ON_RESET (1'b1),
      .CLEAR_VALUE    (16'hA5A5),
      .INIT_FILE      ("init.mif")
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .busy      (busy[g]),
      .en_a      (en_a),
      .we_a      (we_a),
      .be_a      (be_a),
      .addr_a    (addr_a),
      .din_a     (din_a),
      .dout_a    (dout_a[g]),
      .rvalid_a  (rv_a[g]),
      .en_b      (en_b),
      .we_b      (we_b),
      .be_b      (be_b),
      .addr_b    (addr_b),
      .din_b     (din_b),
      .dout_b    (dout_b[g]),
      .rvalid_b  (rv_b[g]),
      .collision (coll[g])
    );
  end

  typedef struct {
    logic          en_a, we_a;
    logic [1:0]    be_a;
    logic [AW-1:0] addr_a;
    logic [DW-1:0] din_a;
    logic          en_b, we_b;
    logic [1:0]    be_b;
    logic [AW-1:0] addr_b;
    logic [DW-1:0] din_b;
    logic [DW-1:0] da0, da1, da2;
    logic          rva;
    logic [DW-1:0] db;
    logic          rvb, coll;
  } vec_t;

  vec_t vecs [16];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en_a = 1'b0; we_a = 1'b0; be_a = 2'b00; addr_a = '0; din_a = '0;
    en_b = 1'b0; we_b = 1'b0; be_b = 2'b00; addr_b = '0; din_b = '0;
  endtask

  // Steps until busy falls (bounded); flags any output activity while busy.
  task automatic count_busy(output int cycles, output logic quiet);
    cycles = 0;
    quiet  = 1'b1;
    while (busy[0] === 1'b1 && cycles < 2000) begin
      step();
      cycles++;
      for (int k = 0; k < NI; k++)
        if (busy[k] === 1'b1 && (rv_a[k] !== 1'b0 || rv_b[k] !== 1'b0 || dout_a[k] !== '0))
          quiet = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cycles;
    logic quiet;
    logic busy_ok;
    logic exp_rv3 [6];
    logic exp_rv0 [6];

    //        ea    wa    bea    aa      dia       eb    wb    beb    ab      dib       da0       da1       da2       rva   db        rvb   coll
    vecs[0]  = '{1'b1, 1'b0, 2'b00, 9'h000, 16'h0000, 1'b1, 1'b0, 2'b00, 9'h1FF, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 16'hA5A5, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 2'b00, 9'h0FF, 16'h0000, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'hA5A5, 16'hA5A5, 16'hA5A5, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 2'b11, 9'h010, 16'h1234, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h1234, 16'hA5A5, 16'hA5A5, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 2'b10, 9'h010, 16'hABCD, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'hAB34, 16'h1234, 16'hA5A5, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 2'b00, 9'h010, 16'h0000, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'hAB34, 16'hAB34, 16'hAB34, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 2'b11, 9'h005, 16'h1111, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h1111, 16'hA5A5, 16'hAB34, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 2'b11, 9'h005, 16'h2222, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h2222, 16'h1111, 16'hAB34, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 2'b11, 9'h003, 16'h0000, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h0000, 16'hA5A5, 16'hAB34, 1'b1, 16'hA5A5, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 2'b00, 9'h003, 16'h0000, 1'b1, 1'b1, 2'b11, 9'h003, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h5555, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 2'b00, 9'h003, 16'h0000, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h5555, 16'h5555, 16'h5555, 1'b1, 16'h5555, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 2'b01, 9'h007, 16'hAAAA, 1'b1, 1'b1, 2'b11, 9'h007, 16'hBBBB, 16'hA5AA, 16'hA5A5, 16'h5555, 1'b1, 16'hBBBB, 1'b1, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 2'b00, 9'h007, 16'h0000, 1'b1, 1'b0, 2'b00, 9'h007, 16'h0000, 16'hBBAA, 16'hBBAA, 16'hBBAA, 1'b1, 16'hBBAA, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 2'b11, 9'h008, 16'h1234, 1'b1, 1'b1, 2'b11, 9'h009, 16'h5678, 16'h1234, 16'hA5A5, 16'hBBAA, 1'b1, 16'h5678, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 2'b00, 9'h008, 16'hFFFF, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h1234, 16'h1234, 16'hBBAA, 1'b1, 16'h5678, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 2'b00, 9'h008, 16'h0000, 1'b1, 1'b0, 2'b00, 9'h009, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 1'b1, 16'h5678, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 1'b0, 1'b0, 2'b00, 9'h000, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 1'b0, 16'h5678, 1'b0, 1'b0};

    // Reset and the clear pass, with writes hammering both ports while busy.
    idle();
    rst = 1'b1;
    step();
    check("reset busy", busy[0], 1'b1);
    check("reset dout_a", dout_a[0], 16'h0000);
    check("reset rvalid_a", rv_a[0], 1'b0);
    check("reset collision", coll[0], 1'b0);
    check("reset dout_a oreg", dout_a[3], 16'h0000);
    rst = 1'b0;
    en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = 9'h000; din_a = 16'h0000;
    en_b = 1'b1; we_b = 1'b1; be_b = 2'b11; addr_b = 9'h1FF; din_b = 16'h0000;
    count_busy(cycles, quiet);
    idle();
    check("clear busy cycles", cycles, 512);
    check("clear outputs quiet", quiet, 1'b1);
    check("clear busy oreg", busy[3], 1'b0);

    // Single-cycle vectors applied back to back.
    for (int i = 0; i < 16; i++) begin
      en_a = vecs[i].en_a; we_a = vecs[i].we_a; be_a = vecs[i].be_a;
      addr_a = vecs[i].addr_a; din_a = vecs[i].din_a;
      en_b = vecs[i].en_b; we_b = vecs[i].we_b; be_b = vecs[i].be_b;
      addr_b = vecs[i].addr_b; din_b = vecs[i].din_b;
      step();
      check($sformatf("v%0d dout_a wfirst", i), dout_a[0], vecs[i].da0);
      check($sformatf("v%0d dout_a rfirst", i), dout_a[1], vecs[i].da1);
      check($sformatf("v%0d dout_a nochange", i), dout_a[2], vecs[i].da2);
      check($sformatf("v%0d rvalid_a", i), rv_a[0], vecs[i].rva);
      check($sformatf("v%0d rvalid_a nochange", i), rv_a[2], vecs[i].rva);
      check($sformatf("v%0d dout_b", i), dout_b[0], vecs[i].db);
      check($sformatf("v%0d rvalid_b", i), rv_b[0], vecs[i].rvb);
      check($sformatf("v%0d collision", i), coll[0], vecs[i].coll);
    end
    idle();

    // Output-register latency: write distinct words, then a 3-read stream.
    for (int k = 0; k < 3; k++) begin
      en_a = 1'b1; we_a = 1'b1; be_a = 2'b11; addr_a = AW'(k); din_a = DW'(16'h0100 + k);
      step();
    end
    idle();
    step(); step(); step();
    exp_rv0 = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_rv3 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 6; t++) begin
      if (t < 3) begin
        en_a = 1'b1; we_a = 1'b0; addr_a = AW'(t);
      end else begin
        idle();
      end
      step();
      check($sformatf("oreg t%0d rvalid_a", t), rv_a[3], exp_rv3[t]);
      check($sformatf("noreg t%0d rvalid_a", t), rv_a[0], exp_rv0[t]);
      if (exp_rv3[t]) check($sformatf("oreg t%0d dout_a", t), dout_a[3], DW'(16'h0100 + t - 1));
      if (exp_rv0[t]) check($sformatf("noreg t%0d dout_a", t), dout_a[0], DW'(16'h0100 + t));
    end

    // Reset reasserted 100 cycles into a clear pass restarts the full sequence.
    rst = 1'b1;
    step();
    rst = 1'b0;
    busy_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (busy[0] !== 1'b1) busy_ok = 1'b0;
    end
    check("midclear busy held", busy_ok, 1'b1);
    rst = 1'b1;
    step();
    check("midclear reset busy", busy[0], 1'b1);
    check("midclear reset dout_a", dout_a[0], 16'h0000);
    rst = 1'b0;
    count_busy(cycles, quiet);
    check("midclear busy cycles", cycles, 512);
    check("midclear outputs quiet", quiet, 1'b1);
    en_a = 1'b1; we_a = 1'b0; addr_a = 9'h001;
    step();
    idle();
    check("post clear dout_a", dout_a[0], 16'hA5A5);
    check("post clear rvalid_a", rv_a[0], 1'b1);
    step();
    check("post clear dout_a oreg", dout_a[3], 16'hA5A5);
    check("post clear rvalid_a oreg", rv_a[3], 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_tdp_param.md
Name: bram_tdp_param

Overview:
Parametrised true dual-port synchronous RAM. It generalises the team's fixed 16x512 dual-port block with configurable data width and depth, per-byte write enables, and a selectable read-during-write mode. It also adds an optional output pipeline register, a post-reset memory-clear sequencer, and write-write collision reporting. It is used as CPU data/instruction memory and as the shared frame/message buffer between the two bus masters.

Parameters:
DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
ADDR_WIDTH, 9, address bits; DEPTH = 2**ADDR_WIDTH.
RDW_MODE, 0, same-port read-during-write: 0 = write-first, 1 = read-first, 2 = no-change.
OUT_REG, 0, 1 adds one output register stage (read latency 2 instead of 1).
CLEAR_ON_RESET, 1, 1 runs the clear sequencer after reset; 0 goes straight to READY.
CLEAR_VALUE, 0, word written to every address by the clear sequencer.
INIT_FILE, "init.mif", preload file bound to the RAM; used only when CLEAR_ON_RESET = 0.

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
busy  out  1  high while the clear sequencer runs; both ports are ignored while high
en_a  in  1  port A access enable
we_a  in  1  port A write (qualified by en_a)
be_a  in  DATA_WIDTH/8  port A byte enables, bit i covers din_a[8i+7:8i]
addr_a  in  ADDR_WIDTH  port A address
din_a  in  DATA_WIDTH  port A write data
dout_a  out  DATA_WIDTH  port A read data
rvalid_a  out  1  pulses high when dout_a carries the result of an accepted access
en_b, we_b, be_b, addr_b, din_b, dout_b, rvalid_b  same as port A, for port B
collision  out  1  pulses high when both ports wrote the same address in the same cycle

Behaviour:
- Reset (rst = 1 at posedge):
  - dout_a, dout_b, rvalid_a, rvalid_b, collision, and all pipeline stages go to 0.
  - Clear counter goes to 0.
  - State goes to CLEAR with busy = 1 if CLEAR_ON_RESET = 1; otherwise state goes to READY with busy = 0.
  - RAM contents are not touched by reset itself.
- FSM states are CLEAR and READY.
  - CLEAR: each posedge with rst = 0 writes CLEAR_VALUE to address cnt, then cnt increments. After writing DEPTH-1, the FSM enters READY and busy becomes 0.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - Reset asserted mid-clear restarts the sequence at address 0.
- While busy = 1: en_a and en_b are ignored, douts hold 0, and rvalids stay 0.
- Accepted access: en_x = 1 and busy = 0.
  - Write (we_x = 1) updates only the bytes where be_x = 1.
  - we_x = 1 with be_x = 0 leaves memory unchanged but still returns read data per RDW_MODE.
- Read latency:
  - OUT_REG = 0: dout_x and rvalid_x are valid 1 cycle after acceptance.
  - OUT_REG = 1: 2 cycles after acceptance.
  - rvalid_x is a single-cycle pulse per accepted access, including writes.
  - dout_x holds its last value when not updated.
- Same-port read-during-write, dout_x returns:
  - RDW_MODE 0 (write-first): the merged post-write word (new enabled bytes plus old other bytes).
  - RDW_MODE 1 (read-first): the pre-write word.
  - RDW_MODE 2 (no-change): dout_x is not updated, but rvalid_x still pulses.
- Cross-port, same address, same cycle:
  - Port X reads while port Y writes: the reader receives the old word.
  - Both ports write: for bytes enabled on both ports, port A's data wins; bytes enabled on only one port take that port's data.
  - collision pulses 1 cycle after the write (not delayed by OUT_REG). No other case asserts collision.
- Addresses are exactly ADDR_WIDTH bits wide, so no out-of-range access exists.
- All outputs are registered; there is no combinational path from inputs to outputs.

Test Plan:
- Clear sequence (defaults, CLEAR_VALUE = 16'hA5A5): pulse rst for 1 cycle. Required: busy is high for exactly 512 cycles and then falls; reads of addr 0, 255, and 511 return A5A5 one cycle later with rvalid = 1. Write attempts while busy leave memory unchanged.
- Byte enables: write A addr 9'h010 din 16'h1234 be 2'b11, then din 16'hABCD be 2'b10, then read. Required: the final read returns 16'hAB34. In RDW_MODE 0, the second write's dout_a shows 16'hAB34.
- RDW modes: with mem[5] = 16'h1111, write 16'h2222 to addr 5 on port A. Required dout_a: 16'h2222 in mode 0, 16'h1111 in mode 1, previous value held in mode 2, with rvalid_a = 1 in all three.
- Collision: both ports write addr 7 in one cycle, A = 16'hAAAA be 2'b01 and B = 16'hBBBB be 2'b11. Required: collision = 1 the next cycle only, and mem[7] reads 16'hBBAA. Writes to different addresses never raise collision.
- Cross-port: A reads addr 3 while B writes 16'h5555 there (old value 16'h0000). Required: dout_a = 16'h0000, and the next read of addr 3 returns 16'h5555.
- OUT_REG = 1 and mid-clear reset: a back-to-back read stream on A (addresses 0, 1, 2) returns data at cycles +2, +3, +4, with rvalid_a high for exactly those 3 cycles. Reasserting rst at clear cycle 100 restarts busy for a full 512 cycles.
